// File: rtl/rr_arbiter4_pkg.sv
// Shared types, widths and the round-robin search for the 4-way arbiter.
package rr_arbiter4_pkg;

    localparam int ONEHOT_W = 4;
    localparam int ID_W     = 2;
    localparam int HOLD_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Return the first set request bit at or above (last + 1), wrapping modulo 4.
    // Callers only use the result when req is non-zero.
    function automatic logic [ID_W-1:0] rr_pick(input logic [ONEHOT_W-1:0] req,
                                                input logic [ID_W-1:0]     last);
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] pick;
        logic            found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= ONEHOT_W; k++) begin
            idx = last + ID_W'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter4_dec.sv
// Purely combinational 2-to-4 one-hot decoder used to build the grant vector.
module dec2to4_onehot
    import rr_arbiter4_pkg::*;
(
    input  logic [ID_W-1:0]     sel,
    output logic [ONEHOT_W-1:0] onehot
);

    // Set exactly the bit addressed by sel.
    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time and a
// one-cycle dead gap between consecutive owners. All outputs are registered.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ONEHOT_W-1:0] req,
    input  logic                done,
    output logic [ONEHOT_W-1:0] gnt,
    output logic [ID_W-1:0]     gnt_id,
    output logic                gnt_valid,
    output logic                timeout
);

    state_t              state_q, state_d;
    logic [ONEHOT_W-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
    logic                gnt_valid_q, gnt_valid_d;
    logic                timeout_q, timeout_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [ID_W-1:0]     last_owner_q, last_owner_d;

    logic [ID_W-1:0]     winner;
    logic [ONEHOT_W-1:0] dec_onehot;
    logic                req_any;
    logic                owner_req;
    logic                hold_expired;

    assign req_any      = |req;
    assign winner       = rr_pick(req, last_owner_q);
    assign owner_req    = req[gnt_id_q];
    assign hold_expired = (hold_q == HOLD_W'(HOLD_MAX - 1));

    // Decode the next owner index so the grant vector can be registered.
    dec2to4_onehot u_dec (
        .sel    (gnt_id_d),
        .onehot (dec_onehot)
    );

    // Next-state, owner selection, hold counting and timeout detection.
    always_comb begin
        state_d      = state_q;
        gnt_id_d     = gnt_id_q;
        hold_d       = hold_q;
        last_owner_d = last_owner_q;
        timeout_d    = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                // GAP re-arbitrates exactly like IDLE; last_owner was already
                // updated on the way into GAP so the rotation advances.
                if (req_any) begin
                    state_d  = GRANT;
                    gnt_id_d = winner;
                    hold_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
                if (done || !owner_req || hold_expired) begin
                    state_d      = GAP;
                    last_owner_d = gnt_id_q;
                    // Only a pure expiry counts as a timeout; done or a
                    // dropped request in the same cycle wins.
                    timeout_d    = hold_expired && !done && owner_req;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant vector and valid follow the next state so they can be registered.
    always_comb begin
        gnt_valid_d = (state_d == GRANT);
        gnt_d       = gnt_valid_d ? dec_onehot : '0;
    end

    // State and output registers; reset clears the grant asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            gnt_id_q     <= '0;
            gnt_valid_q  <= 1'b0;
            timeout_q    <= 1'b0;
            hold_q       <= '0;
            last_owner_q <= ID_W'(ONEHOT_W - 1);
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            gnt_id_q     <= gnt_id_d;
            gnt_valid_q  <= gnt_valid_d;
            timeout_q    <= timeout_d;
            hold_q       <= hold_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the arbiter.
module tb_rr_arbiter4;

    localparam int HOLD_MAX = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int compared;
    int mismatched;

    // Model: current owner (-1 = none), cycles spent in grant, last owner, timeout.
    int m_owner;
    int m_cyc;
    int m_last;
    bit m_to;

    int order [5] = '{0, 1, 2, 3, 0};

    rr_arbiter4 #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_cyc   = 0;
        m_last  = 3;
        m_to    = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic [3:0] exp_gnt;
        exp_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, ".vld"}, 32'(gnt_valid), 32'(m_owner >= 0));
        check({tag, ".to"}, 32'(timeout), 32'(m_to));
        check({tag, ".oh"}, 32'($onehot0(gnt)), 32'd1);
        if (m_owner >= 0) check({tag, ".id"}, 32'(gnt_id), 32'(m_owner));
    endtask

    // One clock: predict from current inputs, take the edge, compare.
    task automatic tick(input string tag);
        int n_owner = m_owner;
        int n_cyc   = m_cyc;
        int n_last  = m_last;
        bit n_to    = 1'b0;
        if (m_owner >= 0) begin
            if (done || !req[m_owner] || m_cyc == HOLD_MAX) begin
                n_to    = !done && req[m_owner] && (m_cyc == HOLD_MAX);
                n_last  = m_owner;
                n_owner = -1;
            end else begin
                n_cyc = m_cyc + 1;
            end
        end else if (req != 4'b0000) begin
            n_owner = pick(req, m_last);
            n_cyc   = 1;
        end
        @(posedge clk);
        #1;
        m_owner = n_owner;
        m_cyc   = n_cyc;
        m_last  = n_last;
        m_to    = n_to;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        #1;
        model_reset();
        check_model("rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        model_reset();
        #1;
        check("rst.gnt", 32'(gnt), 32'h0);
        check("rst.id", 32'(gnt_id), 32'h0);
        check("rst.vld", 32'(gnt_valid), 32'h0);
        check("rst.to", 32'(timeout), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_model("rst2");
        rst_n = 1'b1;

        // Basic grant, release through GAP, rotation to next requester.
        req = 4'b0101;
        tick("b.g0");
        check("b.g0c", 32'(gnt), 32'h1);
        done = 1'b1;
        tick("b.gap");
        check("b.gapc", 32'(gnt), 32'h0);
        done = 1'b0;
        tick("b.g2");
        check("b.g2c", 32'(gnt), 32'h4);
        req = 4'b0000;
        tick("b.rel");
        tick("b.idle");
        done = 1'b1;
        tick("b.done_idle");
        done = 1'b0;

        // All requesting, done each grant: order 0,1,2,3,0.
        do_reset();
        req = 4'b1111;
        tick("rr.0");
        check("rr.id0", 32'(gnt_id), 32'(order[0]));
        for (int i = 1; i < 5; i++) begin
            done = 1'b1;
            tick("rr.gap");
            check("rr.gapc", 32'(gnt_valid), 32'h0);
            done = 1'b0;
            tick("rr.g");
            check("rr.id", 32'(gnt_id), 32'(order[i]));
        end

        // Hold expiry: 8 cycles granted, one timeout GAP, then re-granted.
        do_reset();
        req = 4'b0010;
        tick("to.g");
        for (int i = 1; i < HOLD_MAX; i++) begin
            tick("to.h");
            check("to.hc", 32'(gnt), 32'h2);
        end
        tick("to.gap");
        check("to.gapg", 32'(gnt), 32'h0);
        check("to.pulse", 32'(timeout), 32'h1);
        tick("to.re");
        check("to.reg", 32'(gnt), 32'h2);
        check("to.reto", 32'(timeout), 32'h0);

        // done coincides with expiry: no timeout.
        for (int i = 1; i < HOLD_MAX; i++) tick("dx.h");
        done = 1'b1;
        tick("dx.gap");
        check("dx.to", 32'(timeout), 32'h0);
        check("dx.gnt", 32'(gnt), 32'h0);
        done = 1'b0;

        // Asynchronous reset mid-grant, then first search starts at 0.
        req = 4'b0100;
        tick("ar.g");
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.gnt", 32'(gnt), 32'h0);
        check("ar.vld", 32'(gnt_valid), 32'h0);
        model_reset();
        req = 4'b1000;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick("ar.g3");
        check("ar.g3c", 32'(gnt), 32'h8);

        // Owner drops its request: GAP without timeout.
        do_reset();
        req = 4'b0001;
        tick("dr.g");
        req = 4'b0000;
        tick("dr.gap");
        check("dr.to", 32'(timeout), 32'h0);
        tick("dr.idle");

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 5) == 0);
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter HOLD_MAX, default 8, maximum cycles a grant may be held before forced revocation; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  4  request vector; bit i = requester i wants the shared resource.
REQ-005 done  input  1  current owner releases the resource; sampled only in GRANT.
REQ-006 gnt  output  4  one-hot grant; all-zero when no owner.
REQ-007 gnt_id  output  2  binary index of current owner; valid only when gnt_valid=1.
REQ-008 gnt_valid  output  1  high while any grant is active.
REQ-009 timeout  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX expiry.

Function
REQ-010 The block SHALL implement FSM states IDLE, GRANT, GAP.
REQ-011 IDLE: if req!=0, SHALL select the winner and enter GRANT on the next edge; else stay in IDLE.
REQ-012 Winner SHALL be the first set req bit searching upward, with wrap, from (last_owner+1) mod 4; last_owner resets to 3, so the first search starts at 0.
REQ-013 GRANT: gnt SHALL equal the 2-to-4 one-hot decode of gnt_id (00->0001, 01->0010, 10->0100, 11->1000); gnt_valid=1.
REQ-014 Grant latency SHALL be exactly 1 cycle from req sampled in IDLE to registered gnt.
REQ-015 gnt, gnt_id, gnt_valid and timeout SHALL be registered outputs; no combinational path from req or done.
REQ-016 GRANT -> GAP when done=1, or when the owner's req bit drops, or when the hold counter reaches HOLD_MAX-1.
REQ-017 The hold counter SHALL clear on entry to GRANT, increment each GRANT cycle, and saturate; its width SHALL be 8 bits.
REQ-018 On revocation by the counter without done or req drop in the same cycle, timeout SHALL pulse for the single cycle in which the block is in GAP.
REQ-019 If done and counter expiry coincide, done SHALL take priority and timeout SHALL stay 0.
REQ-020 GAP: gnt=0, gnt_valid=0 for exactly one cycle; last_owner <= gnt_id; then IDLE-arbitration rules apply on the next edge (GAP -> GRANT if req!=0, else IDLE).
REQ-021 Requests arriving or changing during GRANT SHALL NOT affect the current owner.
REQ-022 A requester that was just released SHALL NOT win again while any other req bit is set.
REQ-023 done asserted in IDLE or GAP SHALL be ignored.
REQ-024 gnt SHALL never have more than one bit set in any cycle.

Reset
REQ-025 While rst_n=0: state=IDLE, gnt=0000, gnt_id=00, gnt_valid=0, timeout=0, hold counter=0, last_owner=3.
REQ-026 Assertion mid-GRANT SHALL clear gnt in the same cycle, asynchronously, without waiting for a clock edge.
REQ-027 After deassertion, the first arbitration SHALL occur on the first rising edge with rst_n=1.

Structure
REQ-028 Shared package SHALL hold the state enum (IDLE, GRANT, GAP), the one-hot width constant (4), and the HOLD counter width constant (8).
REQ-029 The one-hot decode SHALL be a sub-module dec2to4_onehot (2-bit in, 4-bit out, purely combinational), whose output is registered into gnt.
REQ-030 The round-robin search SHALL be a combinational function in the package.

Verification
REQ-031 After reset release, req=0101 -> gnt=0001, gnt_id=00 one cycle later; pulse done -> GAP (gnt=0000) for one cycle -> gnt=0100.
REQ-032 req=1111 held constant, with done pulsed each grant -> grant order 0,1,2,3,0.
REQ-033 HOLD_MAX=8, req=0010 held, done never -> gnt=0010 for 8 cycles, then gnt=0000 with timeout=1 for one cycle, then gnt=0010 again.
REQ-034 done and counter expiry in the same cycle -> GAP with timeout=0.
REQ-035 rst_n pulled low mid-GRANT -> gnt=0000 and gnt_valid=0 immediately; after release, req=1000 -> gnt=1000 (last_owner reset to 3, search starts at 0, first set bit is 3).
REQ-036 Owner drops req mid-GRANT (req 0001 -> 0000) -> GAP next cycle, timeout=0; assertion checker confirms gnt is one-hot or zero in every cycle.
